// File: rtl/shop_cmd_assembler_if.sv
// Byte-stream input and parallel command output bundle for shop_cmd_assembler.
// master: the byte source / command consumer side; slave: the assembler.
interface shop_cmd_assembler_if #(
    parameter int unsigned A_NUM_ASCII_CHARS = 7,
    parameter int unsigned U_NUM_BITS        = 4
);
    logic [7:0]                     i_byte;
    logic                           i_byte_vld;
    logic                           o_byte_rdy;
    logic [U_NUM_BITS-1:0]          o_u;
    logic [A_NUM_ASCII_CHARS*8-1:0] o_a;
    logic                           o_rdy;
    logic                           o_err;

    modport master (
        output i_byte, i_byte_vld,
        input  o_byte_rdy, o_u, o_a, o_rdy, o_err
    );

    modport slave (
        input  i_byte, i_byte_vld,
        output o_byte_rdy, o_u, o_a, o_rdy, o_err
    );
endinterface

// File: rtl/shop_cmd_assembler.sv
// shop_cmd_assembler: parses "<hex user>:<command chars><LF>" lines from a
// byte stream into a parallel command word + user id for shop_v.
// Optional feature macro: SHOP_CMD_ERR_CNT_EN adds a saturating 8-bit
// count of dropped (malformed) lines on o_err_cnt.
module shop_cmd_assembler #(
    parameter int unsigned A_NUM_ASCII_CHARS = 7,
    parameter int unsigned U_NUM_BITS        = 4,
    parameter logic [7:0]  TERM_CHAR         = 8'h0A,
    parameter logic [7:0]  SEP_CHAR          = 8'h3A,
    parameter int unsigned HOLDOFF_CYCLES    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    shop_cmd_assembler_if.slave   bus
`ifdef SHOP_CMD_ERR_CNT_EN
    ,
    output logic [7:0]            o_err_cnt
`endif
);
    localparam int unsigned A_W   = A_NUM_ASCII_CHARS * 8;
    localparam int unsigned CNT_W = $clog2(A_NUM_ASCII_CHARS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEP,
        ST_CMD,
        ST_EMIT,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t                state;
    logic [A_W-1:0]        sr;
    logic [CNT_W-1:0]      cnt;
    logic [U_NUM_BITS-1:0] user;
    logic [3:0]            hold_cnt;
    logic [A_W-1:0]        a_q;
    logic [U_NUM_BITS-1:0] u_q;
    logic                  rdy_q;
    logic                  err_q;

    logic                  take;
    logic                  is_hex;
    logic [3:0]            hex_val;
    logic                  is_print;

    assign take     = bus.i_byte_vld && bus.o_byte_rdy;
    assign is_print = (bus.i_byte >= 8'h20) && (bus.i_byte <= 8'h7E);

    // Decode an upper-case hex digit into its value.
    always_comb begin
        is_hex  = 1'b0;
        hex_val = '0;
        if (bus.i_byte >= 8'h30 && bus.i_byte <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = 4'(bus.i_byte - 8'h30);
        end else if (bus.i_byte >= 8'h41 && bus.i_byte <= 8'h46) begin
            is_hex  = 1'b1;
            hex_val = 4'(bus.i_byte - 8'h37);
        end
    end

    // Line-parsing FSM with registered command outputs and strobes.
    // The command word is loaded on the edge that enters EMIT so that it is
    // valid in the same cycle as the o_rdy strobe (cycle after TERM).
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            sr       <= '0;
            cnt      <= '0;
            user     <= '0;
            hold_cnt <= '0;
            a_q      <= '0;
            u_q      <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        if (is_hex) begin
                            user  <= U_NUM_BITS'(hex_val);
                            state <= ST_SEP;
                        end else if (bus.i_byte != TERM_CHAR) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_SEP: begin
                    if (take) begin
                        if (bus.i_byte == SEP_CHAR) begin
                            sr    <= '0;
                            cnt   <= '0;
                            state <= ST_CMD;
                        end else if (bus.i_byte == TERM_CHAR) begin
                            err_q <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_CMD: begin
                    if (take) begin
                        if (bus.i_byte == TERM_CHAR) begin
                            if (cnt != '0) begin
                                a_q   <= sr;
                                u_q   <= user;
                                rdy_q <= 1'b1;
                                state <= ST_EMIT;
                            end else begin
                                err_q <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end else if (bus.i_byte == 8'h0D) begin
                            state <= ST_CMD;
                        end else if (is_print) begin
                            if (cnt < CNT_W'(A_NUM_ASCII_CHARS)) begin
                                sr  <= {sr[A_W-9:0], bus.i_byte};
                                cnt <= cnt + 1'b1;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_EMIT: begin
                    hold_cnt <= '0;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == 4'(HOLDOFF_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (take && bus.i_byte == TERM_CHAR) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_a   = a_q;
    assign bus.o_u   = u_q;
    assign bus.o_rdy = rdy_q;
    assign bus.o_err = err_q;

    // Input ready decoded from registered state; forced low during reset.
    assign bus.o_byte_rdy = i_reset_n &&
                            (state == ST_IDLE || state == ST_SEP ||
                             state == ST_CMD  || state == ST_DRAIN);

`ifdef SHOP_CMD_ERR_CNT_EN
    // Saturating count of dropped lines.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_err_cnt <= '0;
        end else if (err_q && o_err_cnt != 8'hFF) begin
            o_err_cnt <= o_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shop_cmd_assembler.sv
// Directed self-checking bench for shop_cmd_assembler.
module tb_shop_cmd_assembler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shop_cmd_assembler_if #(.A_NUM_ASCII_CHARS(7), .U_NUM_BITS(4)) bus ();

`ifdef SHOP_CMD_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    shop_cmd_assembler #(
        .A_NUM_ASCII_CHARS(7),
        .U_NUM_BITS(4),
        .TERM_CHAR(8'h0A),
        .SEP_CHAR(8'h3A),
        .HOLDOFF_CYCLES(4)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .bus(bus)
`ifdef SHOP_CMD_ERR_CNT_EN
        ,
        .o_err_cnt(err_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int rdy_pulses = 0;
    int err_pulses = 0;
    int low_run = 0;
    int last_low_run = 0;

    // Count output pulses and the length of each o_byte_rdy low stretch.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_rdy) rdy_pulses++;
            if (bus.o_err) err_pulses++;
            if (!bus.o_byte_rdy) begin
                low_run++;
            end else if (low_run != 0) begin
                last_low_run = low_run;
                low_run = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Present one byte and return 1 time unit after the edge that takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.i_byte = b;
        bus.i_byte_vld = 1'b1;
        while (!bus.o_byte_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout observed=%0d expected<100", n);
        end
        @(posedge clk);
        #1;
        bus.i_byte_vld = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    int rp, ep;

    initial begin
        bus.i_byte = 8'h00;
        bus.i_byte_vld = 1'b0;

        // Reset state
        idle(3);
        check("rst_rdy", 64'(bus.o_rdy), 64'(0));
        check("rst_err", 64'(bus.o_err), 64'(0));
        check("rst_a", 64'(bus.o_a), 64'(0));
        check("rst_u", 64'(bus.o_u), 64'(0));
        check("rst_byte_rdy", 64'(bus.o_byte_rdy), 64'(0));
        rst_n = 1'b1;
        idle(1);
        check("post_rst_byte_rdy", 64'(bus.o_byte_rdy), 64'(1));

        // 0:Login
        send_str("0:Login");
        send_byte(8'h0A);
        check("login_rdy", 64'(bus.o_rdy), 64'(1));
        check("login_u", 64'(bus.o_u), 64'(0));
        check("login_a", 64'(bus.o_a), 64'h00_00_4C_6F_67_69_6E);
        check("login_byte_rdy_low", 64'(bus.o_byte_rdy), 64'(0));
        idle(8);
        check("login_rdy_cnt", 64'(rdy_pulses), 64'(1));
        check("login_err_cnt", 64'(err_pulses), 64'(0));

        // 3:AddItem, next line pushed straight into the hold-off window
        send_str("3:AddItem");
        send_byte(8'h0A);
        check("additem_rdy", 64'(bus.o_rdy), 64'(1));
        check("additem_u", 64'(bus.o_u), 64'(3));
        check("additem_a", 64'(bus.o_a), 64'h41_64_64_49_74_65_6D);
        send_byte(8'h35);
        check("holdoff_len", 64'(last_low_run), 64'(5));
        send_str(":Buy");
        send_byte(8'h0A);
        check("buy5_rdy", 64'(bus.o_rdy), 64'(1));
        check("buy5_u", 64'(bus.o_u), 64'(5));
        check("buy5_a", 64'(bus.o_a), 64'h00_00_00_00_42_75_79);
        idle(8);
        check("buy5_rdy_cnt", 64'(rdy_pulses), 64'(3));

        // Malformed lines
        rp = rdy_pulses;
        ep = err_pulses;
        send_str("1:AddItems");
        send_byte(8'h0A);
        check("ovf_err", 64'(bus.o_err), 64'(1));
        check("ovf_byte_rdy", 64'(bus.o_byte_rdy), 64'(1));
        idle(2);
        send_str("G:Buy");
        send_byte(8'h0A);
        check("badu_err", 64'(bus.o_err), 64'(1));
        idle(2);
        send_str("5");
        send_byte(8'h0A);
        check("nosep_err", 64'(bus.o_err), 64'(1));
        idle(2);
        send_str("2:");
        send_byte(8'h0A);
        check("empty_err", 64'(bus.o_err), 64'(1));
        idle(8);
        check("bad_err_cnt", 64'(err_pulses - ep), 64'(4));
        check("bad_rdy_cnt", 64'(rdy_pulses - rp), 64'(0));
        check("bad_a_kept", 64'(bus.o_a), 64'h00_00_00_00_42_75_79);
        check("bad_u_kept", 64'(bus.o_u), 64'(5));

        // 4:Buy with CR before LF, then a bare LF
        send_str("4:Buy");
        send_byte(8'h0D);
        send_byte(8'h0A);
        check("cr_rdy", 64'(bus.o_rdy), 64'(1));
        check("cr_u", 64'(bus.o_u), 64'(4));
        check("cr_a", 64'(bus.o_a), 64'h00_00_00_00_42_75_79);
        idle(8);
        rp = rdy_pulses;
        ep = err_pulses;
        send_byte(8'h0A);
        idle(4);
        check("bare_lf_rdy", 64'(rdy_pulses - rp), 64'(0));
        check("bare_lf_err", 64'(err_pulses - ep), 64'(0));
        check("bare_lf_byte_rdy", 64'(bus.o_byte_rdy), 64'(1));

        // Reset mid-line, then a fresh command
        send_str("1:Del");
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        check("midrst_a", 64'(bus.o_a), 64'(0));
        rst_n = 1'b1;
        ep = err_pulses;
        send_str("2:Logout");
        send_byte(8'h0A);
        check("logout_rdy", 64'(bus.o_rdy), 64'(1));
        check("logout_u", 64'(bus.o_u), 64'(2));
        check("logout_a", 64'(bus.o_a), 64'h00_4C_6F_67_6F_75_74);
        idle(8);
        check("logout_no_err", 64'(err_pulses - ep), 64'(0));

`ifdef SHOP_CMD_ERR_CNT_EN
        check("errcnt_start", 64'(err_cnt), 64'(0));
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h58);
            send_byte(8'h0A);
        end
        idle(3);
        check("errcnt_sat", 64'(err_cnt), 64'hFF);
        send_byte(8'h58);
        send_byte(8'h0A);
        idle(3);
        check("errcnt_stay", 64'(err_cnt), 64'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
